// File: rtl/branch_predictor_2bit.sv
// Bimodal beq predictor: 2-bit saturating counter table indexed by pc[INDEX_BITS+1:2].
// Fetch prediction and decode resolve are combinational; training and statistics update on posedge.
module branch_predictor_2bit #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [PC_WIDTH-1:0]   i_fetch_pc,
  input  logic [31:0]           i_fetch_instr,
  output logic                  o_pred_taken,
  output logic [PC_WIDTH-1:0]   o_pred_target,
  input  logic                  i_dec_branch,
  input  logic                  i_dec_advance,
  input  logic [PC_WIDTH-1:0]   i_dec_pc,
  input  logic                  i_dec_pred_taken,
  input  logic                  i_dec_taken,
  input  logic [PC_WIDTH-1:0]   i_dec_target,
  output logic                  o_mispredict,
  output logic [PC_WIDTH-1:0]   o_redirect_pc,
  output logic [STAT_WIDTH-1:0] o_branch_count,
  output logic [STAT_WIDTH-1:0] o_mispred_count
);

  localparam int         ENTRIES  = 1 << INDEX_BITS;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [1:0] CTR_SNT  = 2'b00;
  localparam logic [1:0] CTR_WNT  = 2'b01;
  localparam logic [1:0] CTR_ST   = 2'b11;

  logic [1:0]            r_table [ENTRIES];
  logic [STAT_WIDTH-1:0] r_branch_count;
  logic [STAT_WIDTH-1:0] r_mispred_count;

  logic                  w_is_beq;
  logic [INDEX_BITS-1:0] w_fidx;
  logic [INDEX_BITS-1:0] w_didx;
  logic [PC_WIDTH-1:0]   w_fetch_seq;
  logic [PC_WIDTH-1:0]   w_imm_ext;
  logic [PC_WIDTH-1:0]   w_taken_tgt;
  logic                  w_upd;
  logic                  w_mispredict;
  logic [1:0]            w_cur_ctr;
  logic [1:0]            w_next_ctr;
  logic [9:0]            w_unused_instr;

  // Register fields are not needed for predecode; only opcode and offset matter.
  assign w_unused_instr = i_fetch_instr[25:16];

  // ---------------- Fetch-side prediction ----------------
  assign w_is_beq    = (i_fetch_instr[31:26] == OP_BEQ);
  assign w_fidx      = i_fetch_pc[INDEX_BITS+1:2];
  assign w_fetch_seq = i_fetch_pc + PC_WIDTH'(4);
  // Word offset sign-extended and scaled to bytes; sum wraps at PC_WIDTH.
  assign w_imm_ext   = {{(PC_WIDTH-18){i_fetch_instr[15]}}, i_fetch_instr[15:0], 2'b00};
  assign w_taken_tgt = w_fetch_seq + w_imm_ext;

  assign o_pred_taken  = w_is_beq & r_table[w_fidx][1];
  assign o_pred_target = o_pred_taken ? w_taken_tgt : w_fetch_seq;

  // ---------------- Decode-side resolve ----------------
  assign w_upd        = i_dec_branch & i_dec_advance;
  assign w_mispredict = w_upd & (i_dec_taken != i_dec_pred_taken);
  assign w_didx       = i_dec_pc[INDEX_BITS+1:2];

  assign o_mispredict  = w_mispredict;
  assign o_redirect_pc = i_dec_taken ? i_dec_target : (i_dec_pc + PC_WIDTH'(4));

  always_comb begin
    w_cur_ctr  = r_table[w_didx];
    w_next_ctr = w_cur_ctr;
    if (i_dec_taken) begin
      if (w_cur_ctr != CTR_ST) w_next_ctr = w_cur_ctr + 2'd1;
    end else begin
      if (w_cur_ctr != CTR_SNT) w_next_ctr = w_cur_ctr - 2'd1;
    end
  end

  // Fetch reads the registered table, so a same-cycle update is seen next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= CTR_WNT;
      end
    end else if (w_upd) begin
      r_table[w_didx] <= w_next_ctr;
    end
  end

  // ---------------- Saturating statistics ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_branch_count  <= '0;
      r_mispred_count <= '0;
    end else begin
      if (w_upd && (r_branch_count != '1)) begin
        r_branch_count <= r_branch_count + STAT_WIDTH'(1);
      end
      if (w_mispredict && (r_mispred_count != '1)) begin
        r_mispred_count <= r_mispred_count + STAT_WIDTH'(1);
      end
    end
  end

  assign o_branch_count  = r_branch_count;
  assign o_mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Scoreboard bench for branch_predictor_2bit: driver pushes expectations from a counter-array model,
// a negedge monitor pops and compares against the combinational outputs.
module tb_branch_predictor_2bit;

  localparam int SW   = 8;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk;
  logic          rst_n;
  logic [31:0]   fetch_pc, fetch_instr, dec_pc, dec_target;
  logic          dec_branch, dec_advance, dec_pred_taken, dec_taken;
  logic          pred_taken, mispredict;
  logic [31:0]   pred_target, redirect_pc;
  logic [SW-1:0] branch_count, mispred_count;

  branch_predictor_2bit #(.PC_WIDTH(32), .INDEX_BITS(6), .STAT_WIDTH(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fetch_pc(fetch_pc), .i_fetch_instr(fetch_instr),
    .o_pred_taken(pred_taken), .o_pred_target(pred_target),
    .i_dec_branch(dec_branch), .i_dec_advance(dec_advance), .i_dec_pc(dec_pc),
    .i_dec_pred_taken(dec_pred_taken), .i_dec_taken(dec_taken), .i_dec_target(dec_target),
    .o_mispredict(mispredict), .o_redirect_pc(redirect_pc),
    .o_branch_count(branch_count), .o_mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] rpc;
    int          bc;
    int          mc;
  } exp_t;

  exp_t q[$];
  int   cnt[64];
  int   m_bc, m_mc;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] beq(input logic [15:0] imm);
    return {6'b000100, 10'd0, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) cnt[i] = 1;
    m_bc = 0;
    m_mc = 0;
  endtask

  // Expectations for the inputs currently applied, using model state before this cycle's update.
  function automatic exp_t predict();
    exp_t e;
    int   fi;
    logic upd;
    fi     = int'(fetch_pc[7:2]);
    e.pt   = (fetch_instr[31:26] == 6'd4) && (cnt[fi] >= 2);
    e.ptgt = e.pt ? fetch_pc + 32'd4 + 32'(int'($signed(fetch_instr[15:0])) * 4)
                  : fetch_pc + 32'd4;
    upd    = dec_branch && dec_advance;
    e.mp   = upd && (dec_taken != dec_pred_taken);
    e.rpc  = dec_taken ? dec_target : dec_pc + 32'd4;
    e.bc   = m_bc;
    e.mc   = m_mc;
    return e;
  endfunction

  task automatic step(input logic [31:0] fpc, input logic [31:0] fin,
                      input logic dbr, input logic dadv, input logic [31:0] dpc,
                      input logic dpt, input logic dtk, input logic [31:0] dtgt);
    exp_t e;
    int   di;
    @(posedge clk);
    #1;
    fetch_pc = fpc; fetch_instr = fin;
    dec_branch = dbr; dec_advance = dadv; dec_pc = dpc;
    dec_pred_taken = dpt; dec_taken = dtk; dec_target = dtgt;
    e = predict();
    q.push_back(e);
    if (dbr && dadv) begin
      di = int'(dpc[7:2]);
      cnt[di] = dtk ? ((cnt[di] < 3) ? cnt[di] + 1 : 3) : ((cnt[di] > 0) ? cnt[di] - 1 : 0);
      if (m_bc < SMAX) m_bc++;
      if (e.mp && (m_mc < SMAX)) m_mc++;
    end
  endtask

  task automatic fetch_only(input logic [31:0] fpc, input logic [31:0] fin);
    step(fpc, fin, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic resolve(input logic [31:0] dpc, input logic dpt, input logic dtk,
                         input logic [31:0] dtgt);
    step(32'h40, beq(16'h0003), 1'b1, 1'b1, dpc, dpt, dtk, dtgt);
  endtask

  task automatic rand_step();
    logic [31:0] fpc, dpc, fin;
    fpc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
    dpc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
    fin = ($urandom_range(0, 9) < 7) ? beq(16'($urandom)) : {6'b100011, 26'($urandom)};
    step(fpc, fin, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, dpc,
         1'($urandom), 1'($urandom), $urandom);
  endtask

  // Drops reset between clock edges and checks the reset state while it is held.
  task automatic async_reset();
    @(posedge clk);
    #1;
    fetch_pc = 32'h40; fetch_instr = beq(16'h0003);
    dec_branch = 1'b0; dec_advance = 1'b0; dec_pc = 32'h0;
    dec_pred_taken = 1'b0; dec_taken = 1'b0; dec_target = 32'h0;
    #2;
    rst_n = 1'b0;
    model_reset();
    q.push_back(predict());
    #4;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pred_taken",  {31'd0, pred_taken}, {31'd0, e.pt});
      chk("pred_target", pred_target, e.ptgt);
      chk("mispredict",  {31'd0, mispredict}, {31'd0, e.mp});
      if (e.mp) chk("redirect_pc", redirect_pc, e.rpc);
      chk("branch_count",  32'(branch_count),  32'(e.bc));
      chk("mispred_count", 32'(mispred_count), 32'(e.mc));
    end
  end

  initial begin
    int budget;
    rst_n = 1'b0;
    fetch_pc = 32'h0; fetch_instr = 32'h0;
    dec_branch = 1'b0; dec_advance = 1'b0; dec_pc = 32'h0;
    dec_pred_taken = 1'b0; dec_taken = 1'b0; dec_target = 32'h0;
    model_reset();
    #2;
    fetch_pc = 32'h40; fetch_instr = beq(16'h0003);
    q.push_back(predict());
    #10;
    rst_n = 1'b1;

    // T1: freshly reset entry is weakly not-taken
    fetch_only(32'h40, beq(16'h0003));
    // T2: two taken resolves against a not-taken prediction
    resolve(32'h40, 1'b0, 1'b1, 32'h50);
    resolve(32'h40, 1'b0, 1'b1, 32'h50);
    fetch_only(32'h40, beq(16'h0003));
    // T3: saturation at strongly taken, then decay to strongly not-taken
    repeat (3) resolve(32'h40, 1'b1, 1'b1, 32'h50);
    repeat (2) resolve(32'h40, 1'b1, 1'b0, 32'h50);
    fetch_only(32'h40, beq(16'h0003));
    repeat (3) resolve(32'h40, 1'b0, 1'b0, 32'h50);
    fetch_only(32'h40, beq(16'h0003));
    // T4: redirect targets in both directions
    resolve(32'h40, 1'b1, 1'b0, 32'h100);
    resolve(32'h40, 1'b0, 1'b1, 32'h100);
    // T5: stalled decode never trains or flushes; non-beq never predicts taken
    step(32'h40, beq(16'h0003), 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 32'h0);
    repeat (3) resolve(32'h40, 1'b1, 1'b1, 32'h50);
    fetch_only(32'h40, 32'h8C00_0003);
    fetch_only(32'h40, beq(16'hFFF0));
    // T6: fetch and decode on the same index in the same cycle
    repeat (3) step(32'h40, beq(16'h0003), 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0);
    fetch_only(32'hFFFF_FFFC, beq(16'h0001));

    repeat (800) rand_step();
    repeat (300) resolve(32'h80, 1'b0, 1'b1, 32'h200);
    fetch_only(32'h80, beq(16'h0004));

    async_reset();
    fetch_only(32'h40, beq(16'h0003));
    repeat (60) rand_step();

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
